// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states and lane widths.
// Helper functions classify ops so the top and the lane aligner agree on them.
package mem_pkg;

    localparam int OP_W_DEF = 3;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RMW  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int LANE_BYTE = 8;
    localparam int LANE_HALF = 16;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Sub-word stores need a read of the old word before the full-word write.
    function automatic logic is_rmw_store(input logic [2:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and misalignment detection from op and the low address bits.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [LANE_BYTE-1:0] sel_byte;
    logic [LANE_HALF-1:0] sel_half;

    // Little-endian: byte k lives in bits [8k+7:8k], half h in [16h+15:16h].
    assign sel_byte = rdata[{addr_lo, 3'b000} +: LANE_BYTE];
    assign sel_half = rdata[{addr_lo[1], 4'b0000} +: LANE_HALF];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        load_data = '0;
        case (op)
            OP_LW:   load_data = rdata;
            OP_LH:   load_data = {{(32-LANE_HALF){sel_half[LANE_HALF-1]}}, sel_half};
            OP_LHU:  load_data = {{(32-LANE_HALF){1'b0}}, sel_half};
            OP_LB:   load_data = {{(32-LANE_BYTE){sel_byte[LANE_BYTE-1]}}, sel_byte};
            OP_LBU:  load_data = {{(32-LANE_BYTE){1'b0}}, sel_byte};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_word = rdata;
        case (op)
            OP_SW:   store_word = wdata;
            OP_SH:   store_word[{addr_lo[1], 4'b0000} +: LANE_HALF] = wdata[LANE_HALF-1:0];
            OP_SB:   store_word[{addr_lo, 3'b000} +: LANE_BYTE]     = wdata[LANE_BYTE-1:0];
            default: store_word = rdata;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:          misaligned = (addr_lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  misaligned = addr_lo[0];
            default:               misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-only data memory.
// Sub-word stores are performed as a read (IDLE) followed by a full-word write (RMW).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_exc,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);

    logic [1:0]  state, state_nxt;
    logic [31:0] rdata_q;
    logic        exc_q;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;

    logic [2:0]  op;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        misaligned;
    logic        accept;

    assign op        = req_op[2:0];
    assign word_addr = {req_addr[31:2], 2'b00};
    assign accept    = req_valid && (state == ST_IDLE);

    // Ready is a pure decode of the state register, so req_valid never reaches it combinationally.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_exc   = resp_valid ? exc_q : 1'b0;

    mem_lane_align u_align (
        .op         (op),
        .addr_lo    (req_addr[1:0]),
        .rdata      (mem_rdata),
        .wdata      (req_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_RESP;
                    if (!misaligned) begin
                        mem_addr = word_addr;
                        if (op == OP_SW) begin
                            mem_wr    = 1'b1;
                            mem_wdata = req_wdata;
                        end else if (is_rmw_store(op)) begin
                            mem_rd    = 1'b1;
                            state_nxt = ST_RMW;
                        end else begin
                            mem_rd = 1'b1;
                        end
                    end
                end
            end
            ST_RMW: begin
                mem_wr    = 1'b1;
                mem_addr  = buf_addr;
                mem_wdata = buf_data;
                state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rdata_q  <= '0;
            exc_q    <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                exc_q   <= misaligned;
                rdata_q <= (misaligned || is_store(op)) ? 32'h0 : load_data;
                if (!misaligned && is_rmw_store(op)) begin
                    buf_addr <= word_addr;
                    buf_data <= store_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word memory model, a reference copy of
// memory for expected data, and an in-order queue of expected responses.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.OP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem_rd ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_mis(input logic [2:0] op, input logic [31:0] addr);
        if (op == OP_LW || op == OP_SW) return addr[1:0] != 2'b00;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return addr[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] word,
                                             input logic [1:0] lo);
        logic [31:0] sh;
        sh = word >> (8 * lo);
        case (op)
            OP_LW:   return word;
            OP_LH:   return 32'($signed(sh[15:0]));
            OP_LHU:  return {16'h0, sh[15:0]};
            OP_LB:   return 32'($signed(sh[7:0]));
            OP_LBU:  return {24'h0, sh[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_store(input logic [2:0] op, input logic [31:0] word,
                                              input logic [31:0] wdata, input logic [1:0] lo);
        logic [31:0] mask;
        if (op == OP_SW) return wdata;
        mask = (op == OP_SH) ? (32'h0000ffff << (8 * lo)) : (32'h000000ff << (8 * lo));
        return (word & ~mask) | ((wdata << (8 * lo)) & mask);
    endfunction

    // Response monitor: every resp_valid must match the head of the queue, on the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_exc", 32'(resp_exc), 32'(e.exc));
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one request and holds it until accepted; req_valid is left high on return.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit expect_resp, output int stalls);
        exp_t       e;
        logic [7:0] idx;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        stalls    = 0;
        while (!req_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        idx     = addr[9:2];
        e.exc   = exp_mis(op, addr);
        e.rdata = 32'h0;
        e.cyc   = cyc + 1;
        if (!e.exc) begin
            if (!is_store(op)) e.rdata = exp_load(op, ref_mem[idx], addr[1:0]);
            else if (expect_resp) ref_mem[idx] = exp_store(op, ref_mem[idx], wdata, addr[1:0]);
            if (is_rmw_store(op)) e.cyc = cyc + 2;
        end
        if (expect_resp) sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int st;
        issue(op, addr, wdata, 1'b1, st);
        req_valid = 1'b0;
        while (!req_ready) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, r0, w0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0]  = 32'hffffffd3; ref_mem[0]  = 32'hffffffd3;
        mem[1]  = 32'h00000003; ref_mem[1]  = 32'h00000003;
        mem[16] = 32'hcafef00d; ref_mem[16] = 32'hcafef00d;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_exc", 32'(resp_exc), 32'h0);
        check("rst_mem_ctl", {30'h0, mem_rd, mem_wr}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Sub-word loads with sign and zero extension.
        single(OP_LB,  32'h0, 32'h0);
        single(OP_LBU, 32'h0, 32'h0);
        single(OP_LH,  32'h2, 32'h0);

        // SB read-modify-write, checked cycle by cycle.
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h5; req_wdata = 32'h000000ab;
        #1;
        check("sb_c0_mem_rd", 32'(mem_rd), 32'h1);
        check("sb_c0_mem_wr", 32'(mem_wr), 32'h0);
        check("sb_c0_mem_addr", mem_addr, 32'h4);
        issue(OP_SB, 32'h5, 32'h000000ab, 1'b1, st);
        req_valid = 1'b0;
        check("sb_c1_mem_wr", 32'(mem_wr), 32'h1);
        check("sb_c1_mem_rd", 32'(mem_rd), 32'h0);
        check("sb_c1_mem_wdata", mem_wdata, 32'h0000ab03);
        check("sb_c1_req_ready", 32'(req_ready), 32'h0);
        while (!req_ready) @(negedge clk);
        check("sb_word1", mem[1], 32'h0000ab03);

        // SH then LW of the same word sees the merged data.
        single(OP_SH, 32'h2, 32'h00001234);
        single(OP_LW, 32'h0, 32'h0);
        check("sh_word0", mem[0], 32'h1234ffd3);

        // Misaligned requests: exception, no memory traffic.
        r0 = rd_cnt; w0 = wr_cnt;
        single(OP_LW, 32'h6, 32'h0);
        single(OP_SH, 32'h3, 32'h0000beef);
        @(negedge clk);
        check("mis_no_rd", rd_cnt, r0);
        check("mis_no_wr", wr_cnt, w0);
        check("mis_word0", mem[0], ref_mem[0]);

        // Back-to-back stream with req_valid held high.
        issue(OP_SW, 32'h8, 32'hdeadbeef, 1'b1, st);
        issue(OP_SB, 32'h9, 32'h00000011, 1'b1, st);
        check("stream_sw_stall", st, 1);
        issue(OP_LW, 32'h8, 32'h0, 1'b1, st);
        check("stream_sb_stall", st, 2);
        issue(OP_LHU, 32'h8, 32'h0, 1'b1, st);
        issue(OP_LB, 32'hb, 32'h0, 1'b1, st);
        req_valid = 1'b0;
        drain();
        check("stream_word2", mem[2], 32'hdead11ef);

        // Peripheral address passes through unchanged.
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h40000040;
        #1;
        check("periph_mem_addr", mem_addr, 32'h40000040);
        single(OP_LW, 32'h40000040, 32'h0);

        // Reset during RMW aborts the store and drops the response.
        issue(OP_SB, 32'h0, 32'h00000055, 1'b0, st);
        req_valid = 1'b0;
        check("abort_in_rmw", 32'(mem_wr), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_mem_wr", 32'(mem_wr), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_word0", mem[0], ref_mem[0]);
        check("abort_ready_after", 32'(req_ready), 32'h1);

        single(OP_LW, 32'h0, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the pipeline MEM stage and the word-only data memory. Accepts one byte, halfword or word request at a time and drives the memory's read-enable, write-enable, address and write-data signals. Returns aligned, sign- or zero-extended load data. Sub-word stores become a two-cycle read-modify-write, because the memory only writes full words.

## Interface
Parameters:
- OP_W, 3, width of the op field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle. Low is a pipeline stall.
- req_op  in  OP_W  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for SB/SH.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  misaligned-access flag, valid with resp_valid.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable; the write commits at the next posedge clk.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data; it is 0 when mem_rd=0.

## Operation
- Byte order is little-endian: byte k of a word is bits [8k+7:8k].
- Misaligned cases:
  - LW/SW with addr[1:0]≠0.
  - LH/LHU/SH with addr[0]≠0.
  - A misaligned request makes no memory access: mem_rd=mem_wr=0.
- State machine: IDLE, RMW, RESP.
- IDLE (req_ready=1). On req_valid:
  - Misaligned: latch exc=1, rdata=0, go to RESP.
  - Load: mem_rd=1 and mem_addr driven combinationally this cycle. Extract the byte/half selected by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), register it, go to RESP.
  - SW: mem_wr=1, mem_wdata=req_wdata this cycle, go to RESP.
  - SH/SB: mem_rd=1 this cycle. Latch the word address and merge the new lane into mem_rdata to form a 32-bit buffer. Go to RMW.
- RMW (req_ready=0): mem_wr=1, mem_addr and mem_wdata from the latched buffer, go to RESP.
- RESP (req_ready=0): resp_valid=1 with the latched rdata/exc, then return to IDLE.
- Outside the cycles listed above, all mem_* outputs are 0.
- req_valid is ignored whenever req_ready=0.
- Upper address bits pass through unchanged, so peripheral words such as 0x40000040 are reachable.

## Timing
- Reset values: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_exc=0; all mem_* = 0; buffer cleared.
- Latency from acceptance to resp_valid:
  - Load, SW, misaligned: 1 cycle.
  - SH/SB: 2 cycles.
- Throughput: one request per 2 cycles (3 for SH/SB).
- req_ready is registered from state and has no combinational path from req_valid.
- Asserting rst during RMW aborts the request: no memory write, no resp_valid.
- Asserting rst in RESP drops the pending response.
- A store and a following load to the same word see the new data, since the write commits before the next accepted request.

## Structure
- Shared package (mem_pkg) holds the op encodings, state encodings, and the LANE_BYTE and LANE_HALF constants.
- One sub-module, mem_lane_align, is purely combinational. It:
  - extracts and extends load data;
  - builds the merged store word;
  - flags misalignment from op and addr[1:0].
- The top level holds the state machine and registers.

## Test plan
Bench memory model: 256 words, combinational read, synchronous write. Preload word0=0xffffffd3, word1=0x00000003.
- LB addr 0x0 → next cycle resp_rdata=0xffffffd3. LBU addr 0x0 → 0x000000d3. LH addr 0x2 → 0xffffffff.
- SB addr 0x5 wdata 0xAB:
  - cycle 0: mem_rd=1;
  - cycle 1: mem_wr=1, mem_wdata=0x0000AB03;
  - word1 becomes 0x0000AB03;
  - resp_valid at cycle 2.
- SH addr 0x2 wdata 0x1234 → word0=0x1234ffd3. A following LW addr 0x0 returns 0x1234ffd3.
- LW addr 0x6 → resp_exc=1, resp_rdata=0, mem_rd and mem_wr never asserted. SH addr 0x3 → resp_exc=1, memory unchanged.
- req_valid held high across a stream of SW, SB, LW → req_ready low during RMW and RESP; each request accepted exactly once; responses in order.
- rst pulsed in the RMW cycle of SB addr 0x0 → word0 unchanged, no resp_valid, req_ready=1 after reset.
